// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arbiter_pkg;

    // Arbiter FSM encoding: idle, fetch port granted, data port granted.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IBUS = 2'd1,
        ARB_DBUS = 2'd2
    } arb_state_t;

    // Fetches always move a full word.
    localparam logic [3:0] ARB_SEL_WORD = 4'b1111;

endpackage

// File: rtl/bus_arbiter_timer.sv
// arb_timer: watchdog for the arbiter. It counts cycles while run is high and
// raises expired during the TIMEOUT-th consecutive cycle. clear restarts it.
module arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = run && (cnt_q == LIMIT);

    // Next count: saturates at the limit, restarts on clear.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between the instruction-fetch port and
// the data port. The data port has fixed priority. One transaction is in flight
// at a time; the slave may insert any number of wait states.
// Optional watchdog: define ARB_TIMEOUT_EN to abort transactions that are not
// acknowledged within TIMEOUT cycles (flagged through if_err_o / mem_err_o).
import bus_arbiter_pkg::*;

module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    // Instruction-fetch port
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    output logic              if_err_o,
    // Data port
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              mem_err_o,
    // Slave bus
    output logic              bus_cyc_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    // Pipeline stall requests
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o
);

    arb_state_t        state_q,     state_d;
    logic              bus_cyc_q,   bus_cyc_d;
    logic              bus_we_q,    bus_we_d;
    logic [3:0]        bus_sel_q,   bus_sel_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              mem_ack_q,   mem_ack_d;
    logic              if_err_q,    if_err_d;
    logic              mem_err_q,   mem_err_d;

    logic              timeout_expired;
    logic              if_go;
    logic              mem_go;

`ifdef ARB_TIMEOUT_EN
    // Watchdog runs only while a transaction is on the bus.
    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_arb_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (bus_cyc_q),
        .clear   (!bus_cyc_q),
        .expired (timeout_expired)
    );
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_expired = 1'b0;
`endif

    // A request whose ack is showing this cycle is the tail of the previous
    // transaction (requester has not dropped req yet), so it must not re-issue.
    assign if_go  = if_req_i  && !if_ack_q;
    assign mem_go = mem_req_i && !mem_ack_q;

    // Next-state and bus-output decode.
    always_comb begin
        // NOTE: every _d is given its hold value first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        bus_cyc_d   = bus_cyc_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_err_d    = 1'b0;
        mem_err_d   = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (mem_go) begin
                    state_d     = ARB_DBUS;
                    bus_cyc_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_sel_d   = mem_sel_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                end else if (if_go) begin
                    state_d     = ARB_IBUS;
                    bus_cyc_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = ARB_SEL_WORD;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = '0;
                end
            end

            ARB_IBUS, ARB_DBUS: begin
                // A slave ack in the expiry cycle still completes normally.
                if (bus_ack_i) begin
                    state_d   = ARB_IDLE;
                    bus_cyc_d = 1'b0;
                    bus_we_d  = 1'b0;
                    if (state_q == ARB_IBUS) begin
                        if_rdata_d  = bus_rdata_i;
                        if_ack_d    = 1'b1;
                    end else begin
                        mem_rdata_d = bus_rdata_i;
                        mem_ack_d   = 1'b1;
                    end
                end else if (timeout_expired) begin
                    state_d   = ARB_IDLE;
                    bus_cyc_d = 1'b0;
                    bus_we_d  = 1'b0;
                    if (state_q == ARB_IBUS) begin
                        if_rdata_d  = '0;
                        if_ack_d    = 1'b1;
                        if_err_d    = 1'b1;
                    end else begin
                        mem_rdata_d = '0;
                        mem_ack_d   = 1'b1;
                        mem_err_d   = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = ARB_IDLE;
                bus_cyc_d = 1'b0;
                bus_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            bus_cyc_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_err_q    <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            bus_cyc_q   <= bus_cyc_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_err_q    <= if_err_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign bus_cyc_o      = bus_cyc_q;
    assign bus_we_o       = bus_we_q;
    assign bus_sel_o      = bus_sel_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign if_rdata_o     = if_rdata_q;
    assign mem_rdata_o    = mem_rdata_q;
    assign if_ack_o       = if_ack_q;
    assign mem_ack_o      = mem_ack_q;
    assign if_err_o       = if_err_q;
    assign mem_err_o      = mem_err_q;

    // Stall while a request is outstanding and not being acknowledged.
    assign stallreq_if_o  = if_req_i  && !if_ack_q;
    assign stallreq_mem_o = mem_req_i && !mem_ack_q;

endmodule
